// File: rtl/regfile_pkg.sv
// Shared defaults and the register-address type for the regfile write scheduler.
package regfile_pkg;

    localparam int unsigned RF_REG_NUM         = 32;
    localparam int unsigned RF_DATA_WIDTH      = 32;
    localparam int unsigned RF_NUM_WRITE_PORTS = 4;

    typedef logic [$clog2(RF_REG_NUM)-1:0] rf_addr_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/regfile_rr_picker.sv
// Combinational round-robin scan: picks up to NUM_WRITE_PORTS valid requesters
// from rr_ptr_i onwards, skipping any whose address was already granted this scan.
module regfile_rr_picker
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 8,
    parameter int unsigned NUM_WRITE_PORTS = RF_NUM_WRITE_PORTS,
    parameter int unsigned AW              = $clog2(RF_REG_NUM),
    parameter int unsigned PW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               valid_i    [0:NUM_REQ-1],
    input  logic [AW-1:0]      addr_i     [0:NUM_REQ-1],
    input  logic [PW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               port_vld_o [0:NUM_WRITE_PORTS-1],
    output logic [PW-1:0]      port_idx_o [0:NUM_WRITE_PORTS-1],
    output logic               any_grant_o,
    output logic [PW-1:0]      next_ptr_o
);

    localparam int unsigned IW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    logic [AW-1:0] port_addr [0:NUM_WRITE_PORTS-1];

    always_comb begin
        int unsigned cnt;
        int unsigned idx;
        logic        conflict;
        cnt         = 0;
        idx         = 0;
        conflict    = 1'b0;
        grant_o     = '0;
        any_grant_o = 1'b0;
        next_ptr_o  = rr_ptr_i;
        for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
            port_vld_o[p] = 1'b0;
            port_idx_o[p] = '0;
            port_addr[p]  = '0;
        end
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr_i) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            // Only slots already filled this scan (p < cnt) can block a later requester.
            conflict = 1'b0;
            for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (p < cnt && port_addr[p] == addr_i[PW'(idx)]) conflict = 1'b1;
            end
            if (valid_i[PW'(idx)] && cnt < NUM_WRITE_PORTS && !conflict) begin
                grant_o[PW'(idx)]     = 1'b1;
                port_vld_o[IW'(cnt)]  = 1'b1;
                port_idx_o[IW'(cnt)]  = PW'(idx);
                port_addr[IW'(cnt)]   = addr_i[PW'(idx)];
                cnt                   = cnt + 1;
                any_grant_o           = 1'b1;
                next_ptr_o            = PW'(wrap_inc(idx, NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write scheduler: round-robin grants onto registered write ports.
// Optional stall counter output enabled by defining REGFILE_WSCHED_STATS_EN.
module regfile_write_sched
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 8,
    parameter int unsigned NUM_WRITE_PORTS = RF_NUM_WRITE_PORTS,
    parameter int unsigned REG_NUM         = RF_REG_NUM,
    parameter int unsigned DATA_WIDTH      = RF_DATA_WIDTH,
    localparam int unsigned AW             = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  reqValid    [0:NUM_REQ-1],
    input  logic [AW-1:0]         reqAddr     [0:NUM_REQ-1],
    input  logic [DATA_WIDTH-1:0] reqData     [0:NUM_REQ-1],
    output logic                  reqReady    [0:NUM_REQ-1],
    output logic                  writeEnable [0:NUM_WRITE_PORTS-1],
    output logic [AW-1:0]         writeAddr   [0:NUM_WRITE_PORTS-1],
    output logic [DATA_WIDTH-1:0] dataInputs  [0:NUM_WRITE_PORTS-1]
`ifdef REGFILE_WSCHED_STATS_EN
    ,
    output logic [15:0]           stallCount
`endif
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  we_q    [0:NUM_WRITE_PORTS-1];
    logic                  we_d    [0:NUM_WRITE_PORTS-1];
    logic [AW-1:0]         waddr_q [0:NUM_WRITE_PORTS-1];
    logic [AW-1:0]         waddr_d [0:NUM_WRITE_PORTS-1];
    logic [DATA_WIDTH-1:0] wdata_q [0:NUM_WRITE_PORTS-1];
    logic [DATA_WIDTH-1:0] wdata_d [0:NUM_WRITE_PORTS-1];

    logic [NUM_REQ-1:0]    grant;
    logic                  port_vld [0:NUM_WRITE_PORTS-1];
    logic [PW-1:0]         port_idx [0:NUM_WRITE_PORTS-1];
    logic                  any_grant;
    logic [PW-1:0]         next_ptr;

    regfile_rr_picker #(
        .NUM_REQ         (NUM_REQ),
        .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
        .AW              (AW),
        .PW              (PW)
    ) u_picker (
        .valid_i     (reqValid),
        .addr_i      (reqAddr),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .port_vld_o  (port_vld),
        .port_idx_o  (port_idx),
        .any_grant_o (any_grant),
        .next_ptr_o  (next_ptr)
    );

    // Grants are masked by hold and reset; the picker's grant already implies reqValid.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            reqReady[i] = grant[i] && !hold && !rst;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!hold && any_grant) rr_ptr_d = next_ptr;
        for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
            we_d[p]    = 1'b0;
            waddr_d[p] = '0;
            wdata_d[p] = '0;
            if (!hold && port_vld[p]) begin
                waddr_d[p] = reqAddr[port_idx[p]];
                wdata_d[p] = reqData[port_idx[p]];
                we_d[p]    = (reqAddr[port_idx[p]] != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
                we_q[p]    <= 1'b0;
                waddr_q[p] <= '0;
                wdata_q[p] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
                we_q[p]    <= we_d[p];
                waddr_q[p] <= waddr_d[p];
                wdata_q[p] <= wdata_d[p];
            end
        end
    end

    assign writeEnable = we_q;
    assign writeAddr   = waddr_q;
    assign dataInputs  = wdata_q;

`ifdef REGFILE_WSCHED_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_now;

    always_comb begin
        stall_now = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (reqValid[i] && !reqReady[i]) stall_now = 1'b1;
        end
        stall_d = stall_q;
        if (stall_now && stall_q != '1) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stallCount = stall_q;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Randomised bench for regfile_write_sched against a scan-order reference model.
module tb_regfile_write_sched;
    import regfile_pkg::*;

    localparam int NR = 8;
    localparam int NP = 4;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        reqValid    [0:NR-1];
    rf_addr_t    reqAddr     [0:NR-1];
    logic [31:0] reqData     [0:NR-1];
    logic        reqReady    [0:NR-1];
    logic        writeEnable [0:NP-1];
    rf_addr_t    writeAddr   [0:NP-1];
    logic [31:0] dataInputs  [0:NP-1];
`ifdef REGFILE_WSCHED_STATS_EN
    logic [15:0] stallCount;
`endif

    regfile_write_sched #(
        .NUM_REQ         (NR),
        .NUM_WRITE_PORTS (NP),
        .REG_NUM         (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .reqValid    (reqValid),
        .reqAddr     (reqAddr),
        .reqData     (reqData),
        .reqReady    (reqReady),
        .writeEnable (writeEnable),
        .writeAddr   (writeAddr),
        .dataInputs  (dataInputs)
`ifdef REGFILE_WSCHED_STATS_EN
        ,
        .stallCount  (stallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_ptr   = 0;
    int m_stall = 0;
    logic [7:0] last_rdy;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int a, input logic [31:0] d);
        reqValid[i] = 1'b1;
        reqAddr[i]  = rf_addr_t'(a);
        reqData[i]  = d;
    endtask

    task automatic chk_ports_idle(input string nm);
        for (int p = 0; p < NP; p++) begin
            chk({nm, "_we"}, writeEnable[p], 0);
            chk({nm, "_wa"}, writeAddr[p], 0);
            chk({nm, "_wd"}, dataInputs[p], 0);
        end
    endtask

    function automatic logic [7:0] ready_vec();
        logic [7:0] v;
        for (int i = 0; i < NR; i++) v[i] = reqReady[i];
        return v;
    endfunction

    // Called just after a falling edge with requests driven; ends on the next falling edge.
    task automatic step(input logic h);
        logic [7:0]  exp_rdy;
        logic        stall;
        logic        hit;
        int          idx;
        int          last;
        rf_addr_t    taken[$];
        logic        e_we[$];
        rf_addr_t    e_wa[$];
        logic [31:0] e_wd[$];
        hold = h;
        #1;
        exp_rdy = '0;
        last    = -1;
        for (int off = 0; off < NR; off++) begin
            idx = (m_ptr + off) % NR;
            hit = 1'b0;
            foreach (taken[k]) if (taken[k] == reqAddr[idx]) hit = 1'b1;
            if (reqValid[idx] && !h && taken.size() < NP && !hit) begin
                exp_rdy[idx] = 1'b1;
                taken.push_back(reqAddr[idx]);
                e_we.push_back(reqAddr[idx] != 0);
                e_wa.push_back(reqAddr[idx]);
                e_wd.push_back(reqData[idx]);
                last = idx;
            end
        end
        last_rdy = ready_vec();
        chk("reqReady", last_rdy, exp_rdy);
        stall = 1'b0;
        for (int i = 0; i < NR; i++) if (reqValid[i] && !exp_rdy[i]) stall = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk("writeEnable", writeEnable[p], (p < e_we.size()) ? e_we[p] : 0);
            chk("writeAddr",   writeAddr[p],   (p < e_wa.size()) ? e_wa[p] : 0);
            chk("dataInputs",  dataInputs[p],  (p < e_wd.size()) ? e_wd[p] : 0);
        end
        if (last >= 0) m_ptr = (last + 1) % NR;
        if (stall && m_stall < 65535) m_stall++;
`ifdef REGFILE_WSCHED_STATS_EN
        chk("stallCount", stallCount, m_stall);
`endif
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) reqValid[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk_ports_idle("rst_async");
        chk("rst_ready", ready_vec(), 0);
        m_ptr   = 0;
        m_stall = 0;
        @(posedge clk);
        #1;
        chk_ports_idle("rst_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < NR; i++) begin
            reqValid[i] = 1'b0;
            reqAddr[i]  = '0;
            reqData[i]  = '0;
        end
        @(posedge clk);
        #1;
        chk_ports_idle("reset");
        chk("reset_ready", ready_vec(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Eight requesters to registers 1..8
        for (int i = 0; i < NR; i++) set_req(i, i + 1, $urandom);
        step(1'b0);
        chk("burst1_rdy", last_rdy, 8'h0F);
        for (int p = 0; p < NP; p++) chk("burst1_addr", writeAddr[p], p + 1);
        step(1'b0);
        chk("burst2_rdy", last_rdy, 8'hF0);
        for (int p = 0; p < NP; p++) chk("burst2_addr", writeAddr[p], p + 5);
        chk("model_ptr_wrap", m_ptr, 0);
        step(1'b0);
        chk_ports_idle("idle");

        // Move the pointer to 6, then a wrapping scan
        for (int i = 0; i < 4; i++) set_req(i, 20 + i, $urandom);
        step(1'b0);
        set_req(4, 24, $urandom);
        set_req(5, 25, $urandom);
        step(1'b0);
        chk("model_ptr6", m_ptr, 6);
        foreach (reqValid[i]) if (i >= 6 || i <= 2) set_req(i, 10 + i, $urandom);
        step(1'b0);
        chk("wrap_rdy", last_rdy, 8'hC3);
        chk("wrap_p0", writeAddr[0], 16);
        chk("wrap_p1", writeAddr[1], 17);
        chk("wrap_p2", writeAddr[2], 10);
        chk("wrap_p3", writeAddr[3], 11);
        chk("model_ptr2", m_ptr, 2);
        step(1'b0);

        // Same-address conflict
        set_req(0, 5, 32'hA0A0_A0A0);
        set_req(1, 5, 32'hB1B1_B1B1);
        step(1'b0);
        chk("conf1_rdy", last_rdy, 8'h01);
        chk("conf1_addr", writeAddr[0], 5);
        chk("conf1_data", dataInputs[0], 32'hA0A0_A0A0);
        step(1'b0);
        chk("conf2_rdy", last_rdy, 8'h02);
        chk("conf2_we", writeEnable[0], 1);
        chk("conf2_data", dataInputs[0], 32'hB1B1_B1B1);

        // Register 0 consumes a slot but does not write
        set_req(2, 0, 32'h0000_DEAD);
        step(1'b0);
        chk("zero_rdy", last_rdy, 8'h04);
        chk("zero_we", writeEnable[0], 0);

        // Hold for three cycles with everything pending
        chk("model_ptr3", m_ptr, 3);
        for (int i = 0; i < NR; i++) set_req(i, i + 1, $urandom);
        begin
            int s0;
            s0 = m_stall;
            for (int c = 0; c < 3; c++) begin
                step(1'b1);
                chk("hold_rdy", last_rdy, 0);
            end
`ifdef REGFILE_WSCHED_STATS_EN
            chk("hold_stall", stallCount, s0 + 3);
`else
            chk("hold_model_stall", m_stall, s0 + 3);
`endif
        end
        step(1'b0);
        chk("after_hold_rdy", last_rdy, 8'h78);

        // Reset in the middle of a burst
        for (int i = 3; i <= 6; i++) set_req(i, i + 1, $urandom);
        mid_reset();
        step(1'b0);
        chk("post_rst_rdy", last_rdy, 8'h0F);
        for (int i = 0; i < NR; i++) reqValid[i] = 1'b0;

        // Random traffic with small address space to provoke conflicts
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!reqValid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 7), $urandom);
            end
            if (c == 200) mid_reset();
            step($urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_sched.md
REGFILE_WRITE_SCHED -- requirements
Module: regfile_write_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8, number of write requesters.
REQ-002 SHALL have parameter NUM_WRITE_PORTS, default 4, register-file write ports driven.
REQ-003 SHALL have parameter REG_NUM, default 32, registers addressed; address width $clog2(REG_NUM).
REQ-004 SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port hold, input, 1, suppress all grants this cycle.
REQ-008 SHALL have port reqValid[0:NUM_REQ-1], input, 1 each, requester has a write pending.
REQ-009 SHALL have port reqAddr[0:NUM_REQ-1], input, $clog2(REG_NUM) each, target register.
REQ-010 SHALL have port reqData[0:NUM_REQ-1], input, DATA_WIDTH each, write data.
REQ-011 SHALL have port reqReady[0:NUM_REQ-1], output, 1 each, combinational grant.
REQ-012 SHALL have port writeEnable[0:NUM_WRITE_PORTS-1], output, 1 each, registered, to regfile.
REQ-013 SHALL have port writeAddr[0:NUM_WRITE_PORTS-1], output, $clog2(REG_NUM) each, registered.
REQ-014 SHALL have port dataInputs[0:NUM_WRITE_PORTS-1], output, DATA_WIDTH each, registered.

Function
REQ-015 SHALL transfer a request on a cycle where reqValid[i] and reqReady[i] are both high; requester holds addr/data stable until transfer.
REQ-016 SHALL scan requesters in round-robin order starting at pointer rrPtr, wrapping NUM_REQ-1 -> 0, granting at most NUM_WRITE_PORTS per cycle.
REQ-017 SHALL deny a valid request whose reqAddr equals that of an earlier-in-scan-order request granted this cycle; it retries next cycle.
REQ-018 SHALL grant requests with reqAddr 0 (consuming a grant slot) but drive writeEnable low for that slot.
REQ-019 SHALL place the k-th grant of the scan on write port k, registered: writeEnable/writeAddr/dataInputs valid exactly one cycle after transfer.
REQ-020 SHALL drive writeEnable low, writeAddr 0, dataInputs 0 on ports with no grant in the prior cycle.
REQ-021 SHALL update rrPtr to (index of last granted requester + 1) mod NUM_REQ; rrPtr unchanged when no grant.
REQ-022 SHALL, while hold is high, drive all reqReady low, hold rrPtr, and register no writes.
REQ-023 SHALL keep reqReady[i] low whenever reqValid[i] is low.

Reset
REQ-024 SHALL on rst asynchronously clear rrPtr to 0, all writeEnable to 0, writeAddr to 0, dataInputs to 0, stats counter to 0.
REQ-025 SHALL drive all reqReady low while rst is high; requests in flight are discarded.
REQ-026 SHALL resume scanning from requester 0 on the first edge after rst deasserts.

Configuration
REQ-027 SHALL, with REGFILE_WSCHED_STATS_EN defined, add output stallCount, 16 bits, incrementing once per cycle in which any reqValid is high with reqReady low, saturating at 0xFFFF.
REQ-028 SHALL, without REGFILE_WSCHED_STATS_EN, omit stallCount port and its logic entirely.

Structure
REQ-029 SHALL take REG_NUM, DATA_WIDTH, NUM_WRITE_PORTS defaults and the register-address typedef from shared package regfile_pkg.
REQ-030 SHALL place the combinational round-robin/conflict scan in sub-module regfile_rr_picker (outputs grant vector and per-port requester index).

Verification
REQ-031 SHALL cover: reset, then 8 requesters valid to addrs 1..8 -> cycle 1 grants 0..3, cycle 2 grants 4..7, ports carry addrs 1..4 then 5..8.
REQ-032 SHALL cover: rrPtr=6, requesters 6,7,0,1,2 valid, distinct addrs -> grants 6,7,0,1 on ports 0..3; rrPtr becomes 2.
REQ-033 SHALL cover: requesters 0 and 1 both to addr 5 -> only 0 granted; 1 granted next cycle; port 0 writes 5 twice in order.
REQ-034 SHALL cover: requester 2 to addr 0 with data 0xDEAD -> reqReady[2] high, slot's writeEnable low next cycle.
REQ-035 SHALL cover: hold high for 3 cycles with all valid -> no grants, rrPtr stable; with STATS_EN stallCount advances by 3.
REQ-036 SHALL cover: rst asserted mid-burst -> writeEnable all 0 immediately, rrPtr 0, first post-reset grant starts at requester 0.
